// File: rtl/fft_frame_streamer.sv
// rtl/fft_frame_streamer.sv - buffered AXI-Stream frame source for the FFT wrapper
//
// Holds one frame of samples, sends a single config word on the config
// channel, then streams the frame (forward or reversed) with tlast on the
// final beat.
//
// Optional feature macro: FFT_STREAM_REPEAT_EN (adds repeat_mode / stop).
//
// Ports:
//   aclk, areset           clock (rising edge), asynchronous active-high reset
//   wr_en/wr_addr/wr_data  buffer write port, ignored while busy
//   start, cfg_word,       transfer request; cfg_word, frame_len and reverse
//   frame_len, reverse     are latched when start is accepted
//   busy, done             transfer in progress / one-cycle completion pulse
//   frame_count            completed frames, wraps at 2^16
//   m_cfg_*                config word channel
//   m_t*                   sample channel
//   repeat_mode, stop      continuous streaming control (macro only)
module fft_frame_streamer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CFG_W  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg_word,
  input  logic [AW:0]       frame_len,
  input  logic              reverse,
`ifdef FFT_STREAM_REPEAT_EN
  input  logic              repeat_mode,
  input  logic              stop,
`endif
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_count,
  output logic [CFG_W-1:0]  m_cfg_tdata,
  output logic              m_cfg_tvalid,
  input  logic              m_cfg_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CFG    = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [AW:0]      len_q, len_d;
  logic             rev_q, rev_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW:0]      beat_q, beat_d;
  logic             done_q, done_d;
  logic [15:0]      fc_q, fc_d;

  logic [AW:0]      eff_len;
  logic [AW:0]      last_beat;
  logic [AW-1:0]    first_idx;
  logic             loop_again;

  // Zero or oversize lengths select the whole buffer.
  assign eff_len   = (frame_len == '0 || frame_len > DEPTH_L) ? DEPTH_L : frame_len;
  assign last_beat = len_q - 1'b1;
  assign first_idx = rev_q ? AW'(last_beat) : '0;

`ifdef FFT_STREAM_REPEAT_EN
  logic rep_q, rep_d;
  logic stop_req_q, stop_req_d;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rep_q      <= 1'b0;
      stop_req_q <= 1'b0;
    end else begin
      rep_q      <= rep_d;
      stop_req_q <= stop_req_d;
    end
  end

  always_comb begin
    rep_d      = rep_q;
    stop_req_d = stop_req_q;
    if (state_q == IDLE) begin
      if (start) begin
        rep_d      = repeat_mode;
        stop_req_d = 1'b0;
      end
    end else if (stop) begin
      stop_req_d = 1'b1;
    end
  end

  // A stop arriving on the final beat's cycle still ends after this frame.
  assign loop_again = rep_q & ~stop_req_q & ~stop;
`else
  assign loop_again = 1'b0;
`endif

  // Buffer has no reset so its contents survive areset.
  always_ff @(posedge aclk) begin
    if (wr_en && state_q == IDLE) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      len_q   <= '0;
      rev_q   <= 1'b0;
      idx_q   <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      len_q   <= len_d;
      rev_q   <= rev_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      fc_q    <= fc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    len_d   = len_q;
    rev_d   = rev_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    fc_d    = fc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CFG;
          cfg_d   = cfg_word;
          len_d   = eff_len;
          rev_d   = reverse;
          idx_d   = reverse ? AW'(eff_len - 1'b1) : '0;
          beat_d  = '0;
        end
      end
      CFG: begin
        if (m_cfg_tready) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (m_tready) begin
          if (beat_q == last_beat) begin
            fc_d = fc_q + 16'd1;
            if (loop_again) begin
              idx_d  = first_idx;
              beat_d = '0;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d  = rev_q ? idx_q - 1'b1 : idx_q + 1'b1;
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign frame_count  = fc_q;
  assign m_cfg_tvalid = (state_q == CFG);
  assign m_cfg_tdata  = m_cfg_tvalid ? cfg_q : '0;
  assign m_tvalid     = (state_q == STREAM);
  assign m_tdata      = m_tvalid ? mem[idx_q] : '0;
  assign m_tlast      = m_tvalid && (beat_q == last_beat);

endmodule

// File: doc/fft_frame_streamer.md
# fft_frame_streamer

Parametrised AXI-Stream frame source that feeds the FFT wrapper. Holds one frame of samples in an internal buffer, sends one configuration word on the FFT config channel, then streams the frame with `tlast` on the final sample. It supports configurable frame length, forward or reversed sample order and full back-pressure. It replaces hand-driven stimulus processes and is also usable as an on-chip test-pattern source.

## Interface
- `DATA_W`, 8: sample width.
- `DEPTH`, 16: buffer depth, power of two, ≥2; `AW = log2(DEPTH)`.
- `CFG_W`, 8: config word width.
- `aclk` in 1: clock, rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `wr_en` in 1: buffer write strobe; ignored while `busy`.
- `wr_addr` in AW: buffer write address.
- `wr_data` in DATA_W: buffer write data.
- `start` in 1: begin a transfer; ignored while `busy`.
- `cfg_word` in CFG_W: config word, latched at `start`.
- `frame_len` in AW+1: samples per frame, latched at `start`; 0 or >DEPTH means DEPTH.
- `reverse` in 1: latched at `start`; 1 streams from index len-1 down to 0.
- `busy` out 1: high from the cycle after `start` until the final handshake completes.
- `done` out 1: one-cycle pulse after the last beat of a transfer.
- `frame_count` out 16: count of completed frames; wraps at 2^16.
- `m_cfg_tdata` out CFG_W, `m_cfg_tvalid` out 1, `m_cfg_tready` in 1: config channel.
- `m_tdata` out DATA_W, `m_tvalid` out 1, `m_tlast` out 1, `m_tready` in 1: sample channel.
- `repeat_mode` in 1 and `stop` in 1: present only with `FFT_STREAM_REPEAT_EN`.

## Operation
- States: IDLE, CFG, STREAM.
- IDLE → CFG when `start` is high at an edge. Latches `cfg_word`, effective length L, `reverse` and (if compiled in) `repeat_mode`. Index = 0 if forward, L-1 if reverse.
- CFG: `m_cfg_tvalid`=1, `m_cfg_tdata`=latched word. On `m_cfg_tvalid & m_cfg_tready` → STREAM.
- STREAM: `m_tvalid`=1, `m_tdata`=buffer[index], `m_tlast`=1 only on beat L of the frame.
  - On each handshake: index ±1, beat count +1.
  - After the handshake of the last beat: → IDLE, `done` pulses, `frame_count`+1.
- AXI rules:
  - Valid never drops without a handshake.
  - Data and last stay stable while valid and not ready.
  - Each beat is sent exactly once, with no duplication or loss.
- The buffer is not reset. Writes in IDLE take effect the next cycle. A write and a `start` on the same edge: the write lands and the frame uses the new value.
- L=1: a single beat, with `m_tlast`=1.
- Reset at any point: state IDLE. `busy`, `done`, `m_cfg_tvalid`, `m_cfg_tdata`, `m_tvalid`, `m_tdata`, `m_tlast`=0 and `frame_count`=0, all asynchronously. Buffer contents are retained.

## Timing
- `start` at edge N: `m_cfg_tvalid` and `busy` high after edge N.
- Config handshake at edge M: first `m_tvalid` after edge M. There is no bubble between beats while `m_tready`=1.
- Throughput is one beat per cycle.
- With ready held high, the last beat's handshake falls at edge M+L. `done` and `frame_count` update after that edge, and `busy` is low in the same cycle.
- Minimum transfer with ready held high: L+1 cycles from the first `m_cfg_tvalid` to `done`.

## Configuration
- `FFT_STREAM_REPEAT_EN` defined:
  - Adds the `repeat_mode` and `stop` ports.
  - If the latched `repeat_mode`=1, the last-beat handshake returns directly to the frame start index in STREAM. There is no config resend and no bubble.
  - `done` does not pulse between frames; `frame_count` increments per frame.
  - A `stop` pulse in any busy cycle sets a sticky request. The current frame completes, then the block goes to IDLE with `done`.
- Not defined: the ports are absent and behaviour is as with `repeat_mode`=0.

## Test plan
- Forward frame: load buffer with 00,07,0A,07,00,F9,F6,F9 repeated twice; `cfg_word`=01, `frame_len`=0, ready=1. Expect:
  - One config beat of 01.
  - 16 beats in buffer order, `m_tlast` on beat 16 only.
  - `done` pulse and `frame_count`=1.
- Reverse: same buffer, `reverse`=1. Expect beats F9,F6,F9,00,07,0A,07,00 twice, and `m_tlast` on the final 00 (index 0).
- Back-pressure: hold `m_cfg_tready` low for 5 cycles, then toggle `m_tready` pseudo-randomly. Expect:
  - Config and sample data stable while stalled.
  - Exactly 16 beats with the correct sequence.
  - `busy` high throughout.
- Short frame: `frame_len`=4. Expect 00,07,0A,07 with `m_tlast` on 07, then IDLE. A following `start` with `frame_len`=17 sends 16 beats.
- Reset mid-frame: assert `areset` after 6 beats. Expect all outputs 0 immediately and `frame_count`=0. A restart sends the full 16 beats from 00 and `frame_count`=1.
- Repeat (macro defined): `repeat_mode`=1, `stop` pulsed during beat 20. Expect:
  - One config beat.
  - 32 sample beats with `m_tlast` on beats 16 and 32.
  - `frame_count`=2 and a single `done` pulse.
